// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: channel indices, the debounce state
// encoding, and a priority helper used by the event serializer.
package btn_pkg;

  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_R = 2;
  localparam int unsigned BTN_L = 3;
  localparam int unsigned BTN_D = 4;

  typedef enum logic [1:0] {
    StLow     = 2'b00,
    StChkHigh = 2'b01,
    StHigh    = 2'b11,
    StChkLow  = 2'b10
  } deb_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// Button pins in, debounced levels / pulses and serialized move events out.
interface btn_event_decoder_if #(
  parameter int unsigned N_BTN = 5
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             evt_valid;
  logic [2:0]       evt_code;
  logic             evt_overrun;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, evt_valid, evt_code, evt_overrun
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, evt_valid, evt_code, evt_overrun
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, then a 4-state stability FSM that emits
// registered press/release pulses and a debounced level.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             meta_q, sync_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StLow: begin
        cnt_d = '0;
        if (sync_q) begin
          state_d = StChkHigh;
          cnt_d   = CntOne;
        end
      end
      StChkHigh: begin
        if (!sync_q) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StHigh;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHigh: begin
        cnt_d = '0;
        if (!sync_q) begin
          state_d = StChkLow;
          cnt_d   = CntOne;
        end
      end
      StChkLow: begin
        if (sync_q) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = StLow;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase
    level_d = (state_d == StHigh) || (state_d == StChkLow);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= StLow;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      meta_q    <= raw_i;
      sync_q    <= meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Debounces every button and serializes accepted presses into one-cycle move events,
// lowest button index first.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  btn_event_decoder_if.slave bus
);

  logic [N_BTN-1:0] level, press, rel;
  logic [N_BTN-1:0] pending_q, pending_d, grant;
  logic             overrun_q, overrun_d;
  logic             evt_valid_q, evt_valid_d;
  logic [2:0]       evt_code_q, evt_code_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (bus.btn_raw[g]),
      .level_o  (level[g]),
      .press_o  (press[g]),
      .release_o(rel[g])
    );
  end

  // The event on the outputs this cycle is the grant; it is retired at the next edge.
  always_comb begin
    grant       = pending_q & (~pending_q + N_BTN'(1));
    pending_d   = (pending_q & ~grant) | press;
    overrun_d   = overrun_q | (|(press & pending_q & ~grant));
    evt_valid_d = |pending_d;
    evt_code_d  = lowest_idx(8'(pending_d));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= '0;
      overrun_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_code    = evt_code_q;
  assign bus.evt_overrun = overrun_q;

endmodule
